// File: rtl/rv32_uart_tx_queue_if.sv
// Bundle of signals between the transmit queue and its neighbours.
//   Write side : wr_en, wr_data, clr_ovf  (into the queue)
//                full, empty, count, overflow (status out of the queue)
//   UART side  : enable, ready (into the queue)
//                new_data, data_tx (out of the queue, towards rv32_uart)
// The master modport belongs to the surrounding logic (core plus UART).
// The slave modport belongs to the queue itself.
interface rv32_uart_tx_queue_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clr_ovf;
  logic             enable;
  logic             ready;
  logic             new_data;
  logic [WIDTH-1:0] data_tx;

  modport master (
    output wr_en, wr_data, clr_ovf, enable, ready,
    input  full, empty, count, overflow, new_data, data_tx
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, enable, ready,
    output full, empty, count, overflow, new_data, data_tx
  );
endinterface

// File: rtl/rv32_uart_tx_queue.sv
// Transmit FIFO that feeds rv32_uart. Words are written on the write side of
// the interface. Each word is issued exactly once, in order, as a one-cycle
// new_data strobe with data_tx held until the next issue. An issue waits for
// the UART to report ready. After an issue the queue waits for ready to drop,
// then waits for it to rise again. If ready never drops within BUSY_TIMEOUT
// cycles, the word is treated as accepted anyway.
// Ports:
//   clk   - single rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - rv32_uart_tx_queue_if.slave: the write side, status flags and
//           the UART handshake
module rv32_uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 32,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  rv32_uart_tx_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, ovf_q;
  logic             new_data_q;
  logic [WIDTH-1:0] data_tx_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic             issue, wr_acc;

  // Flags come from the registered count, so a write into a full FIFO is
  // refused even when a pop happens on the same edge. A word written into an
  // empty FIFO cannot be popped on the same edge.
  assign wr_acc  = bus.wr_en && !full_q;
  assign count_d = count_q + CW'(wr_acc) - CW'(issue);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (issue) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.ready)                        state_d = WAIT_DONE;
        else if (timer_q == TW'(BUSY_TIMEOUT)) state_d = IDLE;
      end
      WAIT_DONE: if (bus.ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic: the issue decision and the ready-never-dropped timer.
  // The timer counts the cycles in which ready stayed high. The word is
  // released on the cycle after the timer reaches BUSY_TIMEOUT, which gives
  // a spacing of BUSY_TIMEOUT+2 cycles between pulses.
  always_comb begin
    issue   = 1'b0;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        issue   = bus.enable && bus.ready && !empty_q;
        timer_d = '0;
      end
      WAIT_BUSY: begin
        if (bus.ready && (timer_q != TW'(BUSY_TIMEOUT))) timer_d = timer_q + TW'(1);
      end
      default: timer_d = timer_q;
    endcase
  end

  // Storage is not reset. Its contents do not matter until a write
  // places a word there.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[tail_q] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      new_data_q <= 1'b0;
      data_tx_q  <= '0;
      timer_q    <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (wr_acc) tail_q <= tail_q + AW'(1);
      if (issue) begin
        head_q    <= head_q + AW'(1);
        data_tx_q <= mem[head_q];
      end
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      new_data_q <= issue;
      timer_q    <= timer_d;
      // When a write overflows and clr_ovf is high on the same edge, set wins.
      if (bus.wr_en && full_q) ovf_q <= 1'b1;
      else if (bus.clr_ovf)    ovf_q <= 1'b0;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.new_data = new_data_q;
  assign bus.data_tx  = data_tx_q;
endmodule

// File: tb/tb_rv32_uart_tx_queue.sv
// Bench for rv32_uart_tx_queue. A queue-based reference model predicts
// occupancy, flags, overflow and the issued word stream. A small UART model
// drives ready. Directed scenarios add literal expectations.
module tb_rv32_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int BT    = 4;

  logic clk;
  logic rst_n;

  rv32_uart_tx_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  rv32_uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BUSY_TIMEOUT(BT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_on   = 0;

  // UART model controls
  bit uart_drop = 1;
  int uart_busy = 3;

  // reference model state
  logic [31:0] mq[$];
  bit          hist[$];
  bit          m_busy = 0;
  bit          m_ovf  = 0;
  bit          m_nd   = 0;
  logic [31:0] m_data = '0;

  // issued-word log
  logic [31:0] log_w[$];
  int          log_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] log_word(input int i);
    if (i < log_w.size()) return log_w[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int log_gap(input int i);
    if (i + 1 < log_c.size()) return log_c[i+1] - log_c[i];
    return -1;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // UART model: it drops ready right after it sees a strobe and stays busy
  // for uart_busy cycles. When uart_drop is 0, ready never drops.
  initial begin
    int busy_left;
    busy_left = 0;
    bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (uart_drop && bus.new_data === 1'b1) begin
        bus.ready = 1'b0;
        busy_left = uart_busy;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.ready = 1'b1;
      end
    end
  end

  // Reference model. After an issue, the link becomes free again in one of
  // two ways. The first is ready seen low and then seen high. The second is
  // BT+1 consecutive samples of ready high.
  initial begin
    int pre_cnt;
    bit pre_busy, do_pop, low, ovf_wr;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        hist.delete();
        m_busy = 0;
        m_ovf  = 0;
        m_nd   = 0;
        m_data = '0;
      end else begin
        pre_cnt  = mq.size();
        pre_busy = m_busy;
        do_pop   = !pre_busy && (bus.enable === 1'b1) && (bus.ready === 1'b1) && (pre_cnt != 0);
        m_nd     = do_pop;
        if (pre_busy) begin
          hist.push_back(bus.ready === 1'b1);
          low = 0;
          foreach (hist[k]) if (!hist[k]) low = 1;
          if ((low && bus.ready === 1'b1) || (!low && hist.size() == BT + 1)) m_busy = 0;
        end
        if (do_pop) begin
          m_data = mq.pop_front();
          m_busy = 1;
          hist.delete();
        end
        ovf_wr = (bus.wr_en === 1'b1) && (pre_cnt == DEPTH);
        if (bus.wr_en === 1'b1 && !ovf_wr) mq.push_back(bus.wr_data);
        if (ovf_wr) m_ovf = 1;
        else if (bus.clr_ovf === 1'b1) m_ovf = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("count",    32'(bus.count),    32'(mq.size()));
        check("full",     32'(bus.full),     32'(mq.size() == DEPTH));
        check("empty",    32'(bus.empty),    32'(mq.size() == 0));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("new_data", 32'(bus.new_data), 32'(m_nd));
        check("data_tx",  bus.data_tx,       m_data);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on && bus.new_data === 1'b1) begin
        log_w.push_back(bus.data_tx);
        log_c.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.enable  = 1'b0;
    log_w.delete();
    log_c.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1;
  endtask

  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_pulses(input string name, input int n, input int bound);
    int seen;
    seen = 0;
    for (int i = 0; i < bound && seen < n; i++) begin
      @(negedge clk);
      if (bus.new_data === 1'b1) seen++;
    end
    check(name, 32'(seen), 32'(n));
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr_ovf = 1'b0;
    bus.enable  = 1'b0;

    // Scenario 1: three words queued while disabled, then drained
    uart_drop = 1; uart_busy = 3;
    do_reset();
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_new_data", 32'(bus.new_data), 32'd0);
    check("rst_data_tx",  bus.data_tx,       32'd0);
    wr(32'h41); wr(32'h42); wr(32'h43);
    idle(3);
    check("s1_count3", 32'(bus.count), 32'd3);
    check("s1_no_pulse", 32'(log_w.size()), 32'd0);
    bus.enable = 1'b1;
    wait_pulses("s1_pulses", 3, 60);
    idle(10);
    check("s1_n",     32'(log_w.size()), 32'd3);
    check("s1_w0",    log_word(0), 32'h41);
    check("s1_w1",    log_word(1), 32'h42);
    check("s1_w2",    log_word(2), 32'h43);
    check("s1_gap0",  32'(log_gap(0)), 32'd5);
    check("s1_gap1",  32'(log_gap(1)), 32'd5);
    check("s1_empty", 32'(bus.empty), 32'd1);

    // Scenario 2: 17 writes, overflow, clear, drain 16
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr(32'h100 + 32'(i));
      if (i == 16) begin
        check("s2_full16", 32'(bus.full),     32'd1);
        check("s2_ovf16",  32'(bus.overflow), 32'd0);
      end
    end
    idle(1);
    check("s2_count", 32'(bus.count),    32'd16);
    check("s2_ovf",   32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    idle(1);
    check("s2_clr", 32'(bus.overflow), 32'd0);
    bus.enable = 1'b1;
    wait_pulses("s2_pulses", 16, 200);
    idle(12);
    check("s2_n", 32'(log_w.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("s2_word", log_word(i), 32'h100 + 32'(i));

    // Scenario 3: full FIFO, pop and write on the same edge
    do_reset();
    for (int i = 0; i < 16; i++) wr(32'h200 + 32'(i));
    @(negedge clk);
    bus.wr_data = 32'hDEAD;
    bus.enable  = 1'b1;
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.enable = 1'b0;
    check("s3_count",    32'(bus.count),    32'd15);
    check("s3_ovf",      32'(bus.overflow), 32'd1);
    check("s3_new_data", 32'(bus.new_data), 32'd1);
    check("s3_data_tx",  bus.data_tx,       32'h200);
    idle(4);
    bus.enable = 1'b1;
    wait_pulses("s3_drain", 15, 200);
    idle(12);
    check("s3_n",    32'(log_w.size()), 32'd16);
    check("s3_last", log_word(15),      32'h20F);

    // Scenario 4: ready never drops, pulses spaced by the timeout
    uart_drop = 0;
    do_reset();
    wr(32'h31); wr(32'h32);
    idle(1);
    bus.enable = 1'b1;
    wait_pulses("s4_pulses", 2, 40);
    idle(15);
    check("s4_n",   32'(log_w.size()), 32'd2);
    check("s4_w0",  log_word(0), 32'h31);
    check("s4_w1",  log_word(1), 32'h32);
    check("s4_gap", 32'(log_gap(0)), 32'(BT + 2));

    // Scenario 5: reset while waiting for the UART to finish
    uart_drop = 1; uart_busy = 8;
    do_reset();
    for (int i = 0; i < 6; i++) wr(32'h500 + 32'(i));
    idle(1);
    bus.enable = 1'b1;
    wait_pulses("s5_first", 1, 20);
    repeat (2) @(negedge clk);
    check("s5_count_pre", 32'(bus.count), 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("s5_count",    32'(bus.count),    32'd0);
    check("s5_new_data", 32'(bus.new_data), 32'd0);
    check("s5_data_tx",  bus.data_tx,       32'd0);
    check("s5_empty",    32'(bus.empty),    32'd1);
    repeat (25) @(negedge clk);
    check("s5_no_more", 32'(log_w.size()), 32'd1);

    // Scenario 6: enable dropped during the strobe, then re-enabled
    uart_busy = 3;
    do_reset();
    wr(32'h61); wr(32'h62);
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.enable = 1'b1;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        @(negedge clk);
        if (bus.new_data === 1'b1) begin
          bus.enable = 1'b0;
          hit = 1;
        end
      end
      check("s6_first", 32'(hit), 32'd1);
    end
    repeat (20) @(negedge clk);
    check("s6_count", 32'(bus.count),    32'd1);
    check("s6_n1",    32'(log_w.size()), 32'd1);
    bus.enable = 1'b1;
    wait_pulses("s6_second", 1, 40);
    idle(8);
    check("s6_n2", 32'(log_w.size()), 32'd2);
    check("s6_w1", log_word(1),      32'h62);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv32_uart_tx_queue.md
# rv32_uart_tx_queue

Transmit-side buffer that sits directly upstream of `rv32_uart`. It accepts 32-bit words from the core or test logic, stores them in a FIFO, and drives the UART's `new_data`/`data_tx` handshake, gated by the UART's `ready`. This replaces ad-hoc free-running stimulus, so every word written is transmitted exactly once, in order.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `WIDTH`, 32: word width; matches `rv32_uart` `data_tx`.
- `BUSY_TIMEOUT`, 4: cycles to wait for `ready` to fall after an issue before treating the word as accepted; ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  WIDTH  write word.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  $clog2(DEPTH+1)  occupancy.
- `overflow`  out  1  sticky: write attempted while full.
- `clr_ovf`  in  1  clears `overflow`.
- `enable`  in  1  allows new transfers to start.
- `ready`  in  1  from `rv32_uart`: idle, can accept.
- `new_data`  out  1  to `rv32_uart`: one-cycle issue strobe.
- `data_tx`  out  WIDTH  to `rv32_uart`: word being issued.

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - Pointers and `count` go to 0 (`empty`=1, `full`=0).
  - `overflow`=0, `new_data`=0, `data_tx`=0, state=IDLE, timeout counter=0.
  - Storage contents are don't-care.
  - Reset mid-transfer discards the queue and any in-flight state immediately. The UART finishes its current frame on its own.
- Write: when `wr_en && !full`, store `wr_data` at the tail, then advance the tail (mod DEPTH).
- Overflow: when `wr_en && full`, drop the word, leave the FIFO unchanged, and set `overflow`.
  - If `clr_ovf` and an overflowing write occur in the same cycle, `overflow` is set (set wins).
- Full/empty flags use the `count` value from before the edge.
  - A write when full is rejected even if a pop happens in the same cycle.
  - A pop requires `!empty` before the edge, so a same-cycle write to an empty FIFO cannot be popped that cycle.
  - A simultaneous accepted write and pop leaves `count` unchanged.
- FSM states:
  - IDLE: if `enable && ready && !empty`, then on that edge:
    - `data_tx` gets the head word; `new_data` goes to 1.
    - The head pointer advances; `count` decrements.
    - Go to WAIT_BUSY and clear the timer.
  - WAIT_BUSY: `new_data` goes to 0 on entry+1, so it is high exactly one cycle.
    - If `ready`=0, go to WAIT_DONE.
    - Otherwise increment the timer; if it reaches `BUSY_TIMEOUT`, go to IDLE.
  - WAIT_DONE: when `ready`=1, go to IDLE.
- `data_tx` holds the last issued word until the next issue.
- `enable` gates only the IDLE→WAIT_BUSY transition. Deasserting it mid-transfer lets the current word finish; no new word starts.
- Pointers wrap at DEPTH. `count` saturates by construction, never exceeding DEPTH or going below 0.

## Timing
- Write-to-`count` update: 1 cycle (registered).
- Empty FIFO, IDLE, `ready`=1, `enable`=1: a word written at edge N gives `new_data`=1 after edge N+1.
- `new_data` is registered, one cycle wide, and always coincides with a valid `data_tx`.
- Minimum spacing between `new_data` pulses:
  - 3 cycles (issue, WAIT_BUSY, WAIT_DONE with `ready` already 1) when the UART drops `ready` the cycle after the issue.
  - `BUSY_TIMEOUT`+2 cycles when `ready` never drops.
- `full`, `empty` and `count` are registered and consistent with each other every cycle.

## Test plan
- Reset with `enable`=0, then write 0x41, 0x42, 0x43:
  - `count`=3, `new_data` stays 0.
  - Raise `enable` with the UART model ready: three `new_data` pulses carrying 0x41, 0x42, 0x43 in order, each separated by the UART busy period; `empty`=1 at the end.
- Write 17 words with DEPTH=16 and `enable`=0:
  - `full`=1 after 16 writes; the 17th is dropped and `overflow`=1.
  - `clr_ovf` clears `overflow`.
  - Drain: exactly 16 words are issued, in order.
- Full FIFO, IDLE, write and pop in the same cycle:
  - The pop issues the head and the write is rejected.
  - `count`=15, `overflow`=1.
- UART model never drops `ready`, BUSY_TIMEOUT=4, 2 words queued:
  - Two pulses exactly 6 cycles apart; no word repeated.
- Hold `rst_n`=0 for one cycle in WAIT_DONE with 5 words queued:
  - The next cycle shows `count`=0, `new_data`=0, `data_tx`=0, state IDLE.
  - No further pulses are issued.
- Deassert `enable` in the cycle `new_data`=1 with 2 words queued:
  - The current transfer completes and no further pulse is issued.
  - Re-enabling issues the remaining word.
